l2_cache_control: RTL

Sequencing FSM for the 2-way, 16-set, 256-bit-line L2 cache datapath. It sits between the upstream requester (L1 arbiter / bus adapter) and the physical-memory cacheline port. It turns `mem_read`/`mem_write` requests into hit service, dirty write-back, line fill and LRU/dirty/valid updates by driving the datapath's control strobes. It also keeps saturating hit/miss/write-back counters for performance debug.

---
 rtl/l2_cache_control.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/l2_cache_control.sv
// Control FSM for the 2-way, 16-set L2 cache datapath: hit service, dirty write-back,
// line fill, LRU/dirty/valid strobes and saturating hit/miss/write-back counters.
module l2_cache_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic             pmem_resp,
    input  logic             hit0,
    input  logic             hit1,
    input  logic             dirty_eviction,
    input  logic             LRU,
    output logic             WE0,
    output logic             WE1,
    output logic             ld_valid0,
    output logic             ld_valid1,
    output logic             ld_dirty0,
    output logic             ld_dirty1,
    output logic             clear_dirty0,
    output logic             clear_dirty1,
    output logic             mem_b_sel,
    output logic             eviction_addr_sel,
    output logic             mem_addr_sel,
    output logic             load_lru,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WRITEBACK, S_FILL} state_t;

    state_t r_state;
    state_t w_next;
    logic   r_victim;
    logic   r_filled;
    logic   w_hit;
    logic   w_hitInc;
    logic   w_missInc;
    logic   w_wbInc;

    assign w_hit     = hit0 | hit1;
    // The CHECK pass that follows a fill completes the request but is not a new hit or miss.
    assign w_hitInc  = (r_state == S_CHECK) && w_hit && !r_filled;
    assign w_missInc = (r_state == S_CHECK) && !w_hit && !r_filled;
    assign w_wbInc   = (r_state == S_WRITEBACK) && pmem_resp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_victim <= 1'b0;
            r_filled <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_CHECK && !w_hit)
                r_victim <= LRU;
            if (r_state == S_FILL && pmem_resp)
                r_filled <= 1'b1;
            else if (r_state == S_CHECK)
                r_filled <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (w_hitInc && hit_count != '1)
                hit_count <= hit_count + 1'b1;
            if (w_missInc && miss_count != '1)
                miss_count <= miss_count + 1'b1;
            if (w_wbInc && wb_count != '1)
                wb_count <= wb_count + 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (mem_read | mem_write) w_next = S_CHECK;
            S_CHECK:     w_next = w_hit ? S_IDLE : (dirty_eviction ? S_WRITEBACK : S_FILL);
            S_WRITEBACK: if (pmem_resp) w_next = S_FILL;
            S_FILL:      if (pmem_resp) w_next = S_CHECK;
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_resp          = 1'b0;
        pmem_read         = 1'b0;
        pmem_write        = 1'b0;
        WE0               = 1'b0;
        WE1               = 1'b0;
        ld_dirty0         = 1'b0;
        ld_dirty1         = 1'b0;
        clear_dirty0      = 1'b0;
        clear_dirty1      = 1'b0;
        mem_b_sel         = 1'b0;
        eviction_addr_sel = 1'b0;
        mem_addr_sel      = 1'b0;
        load_lru          = 1'b0;
        case (r_state)
            S_CHECK: begin
                if (w_hit) begin
                    mem_resp = 1'b1;
                    load_lru = 1'b1;
                    // A write marks the hitting way dirty; way 0 wins if both ways claim a hit.
                    if (mem_write) begin
                        if (hit0) begin
                            WE0       = 1'b1;
                            ld_dirty0 = 1'b1;
                        end else begin
                            WE1       = 1'b1;
                            ld_dirty1 = 1'b1;
                        end
                    end
                end
            end
            S_WRITEBACK: begin
                pmem_write        = 1'b1;
                mem_addr_sel      = 1'b1;
                eviction_addr_sel = r_victim;
                if (pmem_resp) begin
                    if (r_victim) begin
                        ld_dirty1    = 1'b1;
                        clear_dirty1 = 1'b1;
                    end else begin
                        ld_dirty0    = 1'b1;
                        clear_dirty0 = 1'b1;
                    end
                end
            end
            S_FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    mem_b_sel = 1'b1;
                    if (r_victim) begin
                        WE1          = 1'b1;
                        ld_dirty1    = 1'b1;
                        clear_dirty1 = 1'b1;
                    end else begin
                        WE0          = 1'b1;
                        ld_dirty0    = 1'b1;
                        clear_dirty0 = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign ld_valid0 = WE0;
    assign ld_valid1 = WE1;

endmodule
